// File: rtl/bit_reverse_pkg.sv
// Shared definitions for the bit-reverse scheduler: FSM state encoding and
// default geometry.
package bit_reverse_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NREQ  = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_e;

endpackage

// File: rtl/bit_reverse_serial.sv
// Serial bit-reversal engine: src shifts out LSB-first into the bottom of out,
// so after WIDTH enabled cycles out holds src mirrored.
module bit_reverse_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] out_q, out_d;

  always_comb begin
    src_d = src_q;
    out_d = out_q;
    if (load) begin
      src_d = din;
      out_d = '0;
    end else if (en) begin
      out_d = {out_q[WIDTH-2:0], src_q[0]};
      src_d = src_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      out_q <= '0;
    end else begin
      src_q <= src_d;
      out_q <= out_d;
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/bit_reverse_scheduler.sv
// Round-robin arbiter in front of one shared serial bit-reversal engine.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
module bit_reverse_scheduler
  import bit_reverse_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id,
  input  logic                     rsp_ready,
  output state_e                   dbg_state_o,
  output logic [$clog2(WIDTH)-1:0] dbg_cnt_o,
  output logic [IDW-1:0]           dbg_ptr_o
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   cand, gnt_idx;
  logic             gnt_found;
  logic             load, en;
  logic [WIDTH-1:0] words [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = req_data[g*WIDTH +: WIDTH];
  end

  // First valid requester at or above ptr, wrapping around.
  always_comb begin : rr_grant
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr_q) + 32'(i)) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    load      = 1'b0;
    en        = 1'b0;
    req_ready = '0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready = NREQ'(1) << gnt_idx;
          load      = 1'b1;
          id_d      = gnt_idx;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        en    = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end

  bit_reverse_serial #(.WIDTH(WIDTH)) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .din   (words[gnt_idx]),
    .en    (en),
    .dout  (rsp_data)
  );

  assign rsp_id      = id_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_bit_reverse_scheduler.sv
// Self-checking bench for bit_reverse_scheduler: a default 4x8 instance and a
// 3x16 instance, table vectors, reset/backpressure sequences and random traffic.
module tb_bit_reverse_scheduler;
  import bit_reverse_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT A: NREQ=4, WIDTH=8 ----------------
  logic [3:0]  vld_a;
  logic [7:0]  dat_a [4];
  logic [31:0] req_data_a;
  logic [3:0]  req_ready_a;
  logic        rsp_valid_a, rsp_ready_a;
  logic [7:0]  rsp_data_a;
  logic [1:0]  rsp_id_a, dbg_ptr_a;
  logic [2:0]  dbg_cnt_a;
  state_e      dbg_state_a;

  always_comb req_data_a = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

  bit_reverse_scheduler #(.NREQ(4), .WIDTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(vld_a), .req_data(req_data_a),
    .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .rsp_id(rsp_id_a), .rsp_ready(rsp_ready_a), .dbg_state_o(dbg_state_a),
    .dbg_cnt_o(dbg_cnt_a), .dbg_ptr_o(dbg_ptr_a)
  );

  // ---------------- DUT B: NREQ=3, WIDTH=16 ----------------
  logic [2:0]  vld_b;
  logic [15:0] dat_b [3];
  logic [47:0] req_data_b;
  logic [2:0]  req_ready_b;
  logic        rsp_valid_b, rsp_ready_b;
  logic [15:0] rsp_data_b;
  logic [1:0]  rsp_id_b, dbg_ptr_b;
  logic [3:0]  dbg_cnt_b;
  state_e      dbg_state_b;

  always_comb req_data_b = {dat_b[2], dat_b[1], dat_b[0]};

  bit_reverse_scheduler #(.NREQ(3), .WIDTH(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vld_b), .req_data(req_data_b),
    .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .rsp_id(rsp_id_b), .rsp_ready(rsp_ready_b), .dbg_state_o(dbg_state_b),
    .dbg_cnt_o(dbg_cnt_b), .dbg_ptr_o(dbg_ptr_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q [$];   // {expected id, expected data} for DUT A
  int  ptr_m  = 0;         // model round-robin pointer, DUT A
  int  ptr_mb = 0;         // model round-robin pointer, DUT B
  time t_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rev_word(input logic [15:0] x, input int w);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r[w-1-k] = x[k];
    return r;
  endfunction

  function automatic int model_grant(input logic [3:0] v, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      if (v[(p + i) % n]) return (p + i) % n;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  // Expects DUT A idle at entry, serves exactly one request, returns after the
  // response handshake edge. bp = cycles of rsp_ready low once DONE is reached.
  task automatic serve_a(input int bp, input bit refill, input logic [7:0] refill_val,
                         output int got_id, output logic [7:0] got_data);
    int g, lat;
    bit busy_ok, hold_ok;
    logic [15:0] r16;
    logic [9:0]  e;
    logic [7:0]  d_snap;
    logic [1:0]  id_snap;
    got_id      = -1;
    got_data    = '0;
    rsp_ready_a = (bp == 0);
    #1;
    g = model_grant(vld_a, ptr_m, 4);
    if (g < 0) return;
    check("grant_a", 32'(req_ready_a), 32'(4'b0001 << g));
    r16 = rev_word(16'(dat_a[g]), 8);
    exp_q.push_back({2'(g), r16[7:0]});
    @(posedge clk);
    t_acc = $time;
    #1;
    if (refill) dat_a[g] = refill_val;
    else        vld_a[g] = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!rsp_valid_a && lat < 40) begin
      if (req_ready_a != 4'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_a", 32'(lat), 32'd8);
    check("shift_ready_zero", 32'(busy_ok), 32'd1);
    e = exp_q.pop_front();
    check("rsp_id_a", 32'(rsp_id_a), 32'(e[9:8]));
    check("rsp_data_a", 32'(rsp_data_a), 32'(e[7:0]));
    got_id   = int'(rsp_id_a);
    got_data = rsp_data_a;
    if (bp > 0) begin
      hold_ok = 1'b1;
      d_snap  = rsp_data_a;
      id_snap = rsp_id_a;
      repeat (bp) begin
        @(posedge clk);
        #1;
        if (!rsp_valid_a || rsp_data_a !== d_snap || rsp_id_a !== id_snap || req_ready_a != 4'b0)
          hold_ok = 1'b0;
      end
      check("backpressure_hold", 32'(hold_ok), 32'd1);
      rsp_ready_a = 1'b1;
      #1;
      check("done_ready_zero", 32'(req_ready_a), 32'd0);
    end
    @(posedge clk);
    #1;
    check("rsp_valid_drop_a", 32'(rsp_valid_a), 32'd0);
    ptr_m = (g == 3) ? 0 : g + 1;
  endtask

  task automatic serve_b(output int got_id);
    int g, lat;
    logic [15:0] r;
    got_id = -1;
    #1;
    g = model_grant({1'b0, vld_b}, ptr_mb, 3);
    if (g < 0) return;
    check("grant_b", 32'(req_ready_b), 32'(3'b001 << g));
    r = rev_word(dat_b[g], 16);
    @(posedge clk);
    #1;
    lat = 0;
    while (!rsp_valid_b && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_b", 32'(lat), 32'd16);
    check("rsp_data_b", 32'(rsp_data_b), 32'(r));
    check("rsp_id_b", 32'(rsp_id_b), 32'(g));
    got_id = int'(rsp_id_b);
    @(posedge clk);
    #1;
    ptr_mb = (g == 2) ? 0 : g + 1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]  add;       // requesters raising valid before this operation
    logic [31:0] data;      // {d3, d2, d1, d0}
    int          bp;
    int          exp_id;
    logic [7:0]  exp_rsp;
  } vec_t;

  vec_t tbl [8];

  // ---------------- main sequence ----------------
  initial begin
    int gi;
    logic [7:0] gd;
    time t_prev;

    tbl[0] = '{4'b0001, 32'h0000_00CA, 0, 0, 8'h53};
    tbl[1] = '{4'b0100, 32'h000F_0000, 0, 2, 8'hF0};
    tbl[2] = '{4'b1111, 32'h0804_0201, 0, 3, 8'h10};
    tbl[3] = '{4'b0000, 32'h0000_0000, 0, 0, 8'h80};
    tbl[4] = '{4'b0000, 32'h0000_0000, 0, 1, 8'h40};
    tbl[5] = '{4'b0000, 32'h0000_0000, 0, 2, 8'h20};
    tbl[6] = '{4'b0011, 32'h0000_F112, 5, 0, 8'h48};
    tbl[7] = '{4'b0000, 32'h0000_0000, 0, 1, 8'h8F};

    rst_n       = 1'b0;
    vld_a       = 4'b0100;
    rsp_ready_a = 1'b0;
    vld_b       = 3'b000;
    rsp_ready_b = 1'b0;
    for (int i = 0; i < 4; i++) dat_a[i] = '0;
    for (int i = 0; i < 3; i++) dat_b[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("reset_rsp_data", 32'(rsp_data_a), 32'd0);
    check("reset_rsp_id", 32'(rsp_id_a), 32'd0);
    check("reset_state", 32'(dbg_state_a), 32'(S_IDLE));
    check("reset_ptr", 32'(dbg_ptr_a), 32'd0);
    check("reset_cnt", 32'(dbg_cnt_a), 32'd0);
    check("reset_grant", 32'(req_ready_a), 32'(4'b0100));
    vld_a = 4'b0000;
    #1;
    check("idle_no_request", 32'(req_ready_a), 32'd0);
    rst_n = 1'b1;

    // Table: single request, round-robin order, backpressure
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (tbl[k].add[i]) begin
          vld_a[i] = 1'b1;
          dat_a[i] = tbl[k].data[i*8 +: 8];
        end
      end
      serve_a(tbl[k].bp, 1'b0, 8'h00, gi, gd);
      check("tbl_id", 32'(gi), 32'(tbl[k].exp_id));
      check("tbl_rsp", 32'(gd), 32'(tbl[k].exp_rsp));
    end

    // Reset in the middle of SHIFT, between clock edges
    vld_a       = 4'b1000;
    dat_a[3]    = 8'h77;
    rsp_ready_a = 1'b1;
    #1;
    check("pre_reset_grant", 32'(req_ready_a), 32'(4'b1000));
    @(posedge clk);
    #1;
    vld_a = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_cnt", 32'(dbg_cnt_a), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("midrst_rsp_data", 32'(rsp_data_a), 32'd0);
    check("midrst_ptr", 32'(dbg_ptr_a), 32'd0);
    check("midrst_state", 32'(dbg_state_a), 32'(S_IDLE));
    vld_a    = 4'b1010;
    dat_a[1] = 8'h3A;
    dat_a[3] = 8'hC1;
    #1;
    check("midrst_grant_from_0", 32'(req_ready_a), 32'(4'b0010));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr_m = 0;
    exp_q.delete();
    serve_a(0, 1'b0, 8'h00, gi, gd);
    serve_a(2, 1'b0, 8'h00, gi, gd);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!vld_a[i] && $urandom_range(0, 1) == 1) begin
          vld_a[i] = 1'b1;
          dat_a[i] = 8'($urandom);
        end
      end
      if (vld_a == 4'b0) begin
        gi        = int'($urandom_range(0, 3));
        vld_a[gi] = 1'b1;
        dat_a[gi] = 8'($urandom);
      end
      serve_a(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom), gi, gd);
    end
    for (int k = 0; k < 8 && vld_a != 4'b0; k++) serve_a(0, 1'b0, 8'h00, gi, gd);

    // Exhaustive back-to-back on requester 1
    vld_a[1] = 1'b1;
    dat_a[1] = 8'h00;
    t_prev   = 0;
    for (int v = 0; v < 256; v++) begin
      serve_a(0, (v < 255), 8'(v + 1), gi, gd);
      check("exh_id", 32'(gi), 32'd1);
      if (v > 0) check("exh_period", 32'((t_acc - t_prev) / 10), 32'd10);
      t_prev = t_acc;
    end

    // Parameter variant: WIDTH=16, NREQ=3
    rsp_ready_b = 1'b1;
    dat_b[0]    = 16'h0001;
    dat_b[1]    = 16'($urandom);
    dat_b[2]    = 16'($urandom);
    vld_b       = 3'b111;
    serve_b(gi);
    check("b_first_rsp", 32'(rsp_data_b), 32'h8000);
    serve_b(gi);
    serve_b(gi);
    check("b_third_id", 32'(gi), 32'd2);
    serve_b(gi);
    check("b_wrap_id", 32'(gi), 32'd0);
    vld_b = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_reverse_scheduler.md
# bit_reverse_scheduler

Shares one serial bit-reversal engine between `NREQ` requesters under round-robin arbitration. Each granted word is reversed over `WIDTH` clock cycles (LSB-first shift) and returned on a single response port tagged with the requester index. The block sits between several producers of bit-reversal work and their common consumer, replacing per-requester combinational reversers when area matters more than throughput.

## Interface
- `NREQ`, default 4: number of requesters, at least 2.
- `WIDTH`, default 8: data word width, at least 2.
- `IDW`, default `$clog2(NREQ)`: width of the requester tag.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_data`  in  NREQ*WIDTH  request words; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ  one-hot acceptance; a handshake occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  result available.
- `rsp_data`  out  WIDTH  bit-reversed word: `rsp_data[WIDTH-1-k] = src[k]`.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`.
- `rsp_ready`  in  1  consumer accepts the result.

## Operation
- The FSM has three states:
  - `IDLE`: no work in flight.
  - `SHIFT`: engine running, shift counter `cnt` in 0..WIDTH-1.
  - `DONE`: result held for the consumer.
- **IDLE:**
  - `req_ready` is the one-hot round-robin grant over `req_valid`. The search starts at pointer `ptr` and moves upward with wrap-around. `req_ready` is all-zero when no request is valid.
  - On the handshake edge, the block captures the grant index into `rsp_id` and loads the engine with the granted word. It clears `cnt` and moves to `SHIFT`.
- **SHIFT:**
  - Each edge: `out <= {out[WIDTH-2:0], src[0]}`, `src <= src >> 1`, `cnt <= cnt + 1`.
  - On the edge where `cnt == WIDTH-1`, the FSM moves to `DONE`.
  - `req_ready` is all-zero.
- **DONE:**
  - `rsp_valid` is 1. `rsp_data` and `rsp_id` stay stable until the handshake.
  - On the `rsp_ready` edge: move to `IDLE` and set `ptr <= (rsp_id == NREQ-1) ? 0 : rsp_id + 1`.
- Requesters must not make `req_valid` depend on `req_ready`. `req_ready` is combinational from `req_valid`, state and `ptr`.
- Once a requester raises `req_valid`, it keeps `req_valid` and its data stable until its handshake.
- Only one operation is ever in flight. Requests arriving in `SHIFT` or `DONE` wait.
- **Reset:** takes effect immediately, including mid-`SHIFT` or in `DONE`. The in-flight word is discarded, not replayed. After reset:
  - state `IDLE`, `ptr` 0, `cnt` 0;
  - `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0;
  - `req_ready` reflects the grant from `ptr` 0.

## Timing
- **Latency:** with accept edge E0, `rsp_valid` rises after edge E(WIDTH), i.e. WIDTH cycles later.
- **Throughput:** with `rsp_ready` held at 1, the response handshake happens at E(WIDTH+1). The next grant is available in the following cycle, so one word completes every WIDTH+2 cycles.
- **Backpressure:** while `rsp_ready` is low, `DONE` holds indefinitely. No grant is issued and the outputs do not change.
- **Fairness:** a continuously valid requester waits at most NREQ-1 other operations before its grant.

## Structure
- **Shared package `bit_reverse_pkg`:** state encoding localparams `S_IDLE`, `S_SHIFT`, `S_DONE`, plus the default `WIDTH` and `NREQ` constants.
- **Sub-module `bit_reverse_serial`:**
  - Ports: `clk`, `rst_n`, `load`, `din[WIDTH]`, `en`, `dout[WIDTH]`.
  - Contents: the `src` and `out` shift registers only.
  - Unit-tested standalone.
- **Top level:** the FSM, `cnt`, `ptr` and the round-robin grant logic.

## Test plan
- **Single request:** after reset, requester 0 sends 8'b1100_1010 with `rsp_ready`=1. Required: `rsp_data`=8'b0101_0011 and `rsp_id`=0 with `rsp_valid` rising exactly 8 cycles after the accept edge; `req_ready` is all-zero throughout `SHIFT`.
- **Round-robin order:** requester 2 is served alone first. Then all four requesters are valid with data 8'h01, 8'h02, 8'h04, 8'h08. Required: grants in order 3, 0, 1, 2; responses 8'h10, 8'h80, 8'h40, 8'h20 with matching `rsp_id`.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in `DONE` while requester 1 is valid. Required: `rsp_data` and `rsp_id` stay stable, and `req_ready` stays 0 until one cycle after `rsp_ready` rises.
- **Reset mid-operation:** assert `rst_n`=0 at `cnt`=3, asynchronously, between clock edges. Required: `rsp_valid`=0, `rsp_data`=0 and `ptr`=0 immediately; after release, a new request completes normally.
- **Exhaustive and back-to-back:** requester 1 sends all 256 values back-to-back. Required: every response matches the reference reversal, and the measured period is 10 cycles per word.
- **Parameter variant:** `WIDTH`=16, `NREQ`=3. Input 16'h0001 returns 16'h8000, and the tag wraps from 2 to 0.
